// File: rtl/cram_loader_pkg.sv
// Shared types and constants for the CRAM chain loader.
package cram_loader_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_LOAD   = 2'd1;
  localparam state_t ST_FINISH = 2'd2;

  // Bit counter must be able to hold the full chain length.
  function automatic int cnt_width(input int chain_len);
    return $clog2(chain_len + 1);
  endfunction

endpackage

// File: rtl/cram_loader_if.sv
// Configuration word stream in, readback word stream out.
interface cram_loader_if #(parameter int WORD_W = 8) ();

  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [WORD_W-1:0] rb_data;
  logic              rb_valid;

  modport master (output cfg_data, cfg_valid, input cfg_ready, rb_data, rb_valid);
  modport slave  (input cfg_data, cfg_valid, output cfg_ready, rb_data, rb_valid);

endinterface

// File: rtl/cram_rb_packer.sv
// Serial-to-parallel packer: first bit lands in bit 0; flush emits a zero-padded partial word.
module cram_rb_packer #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              bit_in,
  input  logic              bit_en,
  input  logic              flush,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  logic [WORD_W-1:0] acc;
  logic [WORD_W-1:0] acc_nxt;
  logic [IDX_W-1:0]  idx;
  logic              full;
  logic              emit;

  always_comb begin
    acc_nxt = acc;
    if (bit_en) acc_nxt[idx] = bit_in;
  end

  assign full = bit_en && (idx == IDX_W'(WORD_W - 1));
  assign emit = full || (flush && (bit_en || (idx != '0)));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc      <= '0;
      idx      <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= emit;
      if (emit) begin
        rb_data <= acc_nxt;
        acc     <= '0;
        idx     <= '0;
      end else if (bit_en) begin
        acc <= acc_nxt;
        idx <= idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/cram_loader.sv
// Serial CRAM chain loader: streams words LSB-first into the chain, packs old contents as readback.
//   state     | meaning
//   ST_IDLE   | waiting for start; fabric holds its last enable state
//   ST_LOAD   | accepting words and shifting the chain; fabric disabled and in reset
//   ST_FINISH | one cycle after the final shift; pulses done and releases the fabric
module cram_loader
  import cram_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 256,
  parameter int WORD_W    = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  cram_loader_if.slave cfg,
  output logic         config_data_out,
  output logic         config_en,
  input  logic         config_data_in,
  output logic         le_en,
  output logic         le_nrst,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int CNT_W = cnt_width(CHAIN_LEN);
  localparam int BL_W  = $clog2(WORD_W + 1);

  state_t            state;
  logic [WORD_W-1:0] sreg;
  logic [BL_W-1:0]   bits_left;
  logic [CNT_W-1:0]  bit_cnt;
  logic              dout_hold;
  logic              err_q;
  logic              le_q;

  logic shift;
  logic last_shift;
  logic room;
  logic take;
  logic start_ok;
  logic abort_ok;

  assign shift      = (state == ST_LOAD) && (bits_left != '0);
  assign last_shift = shift && (bit_cnt == CNT_W'(CHAIN_LEN - 1));
  // A new word is only useful if at least one more shift remains after this cycle.
  assign room       = shift ? (bit_cnt < CNT_W'(CHAIN_LEN - 1)) : (bit_cnt < CNT_W'(CHAIN_LEN));
  assign start_ok   = (state == ST_IDLE) && start && !abort;
  assign abort_ok   = (state == ST_LOAD) && abort;

  assign cfg.cfg_ready = (state == ST_LOAD) && room &&
                         ((bits_left == '0) || ((bits_left == BL_W'(1)) && shift));
  assign take          = cfg.cfg_valid && cfg.cfg_ready;

  assign config_en       = shift;
  assign config_data_out = shift ? sreg[0] : dout_hold;
  assign busy            = (state != ST_IDLE);
  assign done            = (state == ST_FINISH);
  assign err             = err_q;
  assign le_en           = le_q;
  assign le_nrst         = le_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      sreg      <= '0;
      bits_left <= '0;
      bit_cnt   <= '0;
      dout_hold <= 1'b0;
      err_q     <= 1'b0;
      le_q      <= 1'b0;
    end else begin
      err_q <= abort_ok;
      if (shift) dout_hold <= sreg[0];
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            state     <= ST_LOAD;
            bit_cnt   <= '0;
            bits_left <= '0;
            le_q      <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (abort_ok) begin
            state     <= ST_IDLE;
            sreg      <= '0;
            bits_left <= '0;
          end else begin
            if (shift) bit_cnt <= bit_cnt + CNT_W'(1);
            // Leftover bits of the final word are dropped once the chain is full.
            if (last_shift) begin
              state     <= ST_FINISH;
              sreg      <= '0;
              bits_left <= '0;
            end else if (take) begin
              sreg      <= cfg.cfg_data;
              bits_left <= BL_W'(WORD_W);
            end else if (shift) begin
              sreg      <= sreg >> 1;
              bits_left <= bits_left - BL_W'(1);
            end
          end
        end
        ST_FINISH: begin
          state <= ST_IDLE;
          le_q  <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  cram_rb_packer #(.WORD_W(WORD_W)) u_packer (
    .clk      (clk),
    .rst      (rst),
    .clear    (start_ok || abort_ok),
    .bit_in   (config_data_in),
    .bit_en   (shift),
    .flush    (last_shift),
    .rb_data  (cfg.rb_data),
    .rb_valid (cfg.rb_valid)
  );

endmodule

// File: tb/tb_cram_loader.sv
// Directed bench for cram_loader with a 12-bit chain model and 8-bit words.
module tb_cram_loader;

  localparam int CL = 12;
  localparam int WW = 8;

  logic clk = 1'b0;
  logic rst, start, abort;
  logic config_data_out, config_en, config_data_in;
  logic le_en, le_nrst, busy, done, err;

  cram_loader_if #(.WORD_W(WW)) cfg ();

  cram_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .abort           (abort),
    .cfg             (cfg),
    .config_data_out (config_data_out),
    .config_en       (config_en),
    .config_data_in  (config_data_in),
    .le_en           (le_en),
    .le_nrst         (le_nrst),
    .busy            (busy),
    .done            (done),
    .err             (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [CL-1:0] chain;
  assign config_data_in = chain[CL-1];

  int   cyc = 0;
  logic en_log [0:1023];
  int   en_cnt = 0;
  logic [7:0] rb_log [0:255];
  int   rb_cnt = 0, hs_cnt = 0, done_cnt = 0, err_cnt = 0;

  logic [7:0] src_w [0:3];
  int   src_n = 0, src_idx = 0;
  bit   src_on = 0;
  int   stall_from = 0, stall_len = 0;

  typedef struct {
    logic       st;
    logic       vld;
    logic [7:0] dat;
    logic [8:0] exp;     // {ready,en,dout,done,busy,le_en,le_nrst,rb_valid,err}
    logic [7:0] exp_rb;
  } row_t;

  row_t rows [0:15];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic drive_src();
    cfg.cfg_valid = (src_idx < src_n) && !(cyc >= stall_from && cyc < stall_from + stall_len);
    cfg.cfg_data  = (src_idx < src_n) ? src_w[src_idx] : 8'h00;
  endtask

  // Samples the current cycle, advances one clock, lands on the next negedge.
  task automatic tick();
    logic en_s, d_s, hs_s;
    #1;
    en_s = config_en;
    d_s  = config_data_out;
    hs_s = cfg.cfg_valid && cfg.cfg_ready;
    if (en_s && en_cnt < 1024) begin en_log[en_cnt] = d_s; en_cnt++; end
    if (hs_s) hs_cnt++;
    if (cfg.rb_valid && rb_cnt < 256) begin rb_log[rb_cnt] = cfg.rb_data; rb_cnt++; end
    if (done) done_cnt++;
    if (err) err_cnt++;
    @(posedge clk);
    #1;
    if (en_s) chain = {chain[CL-2:0], d_s};
    start = 1'b0;
    abort = 1'b0;
    cyc++;
    if (src_on) begin
      if (hs_s) src_idx++;
      drive_src();
    end
    @(negedge clk);
  endtask

  task automatic begin_load(input logic [7:0] w0, input logic [7:0] w1);
    src_w[0] = w0;
    src_w[1] = w1;
    src_n    = 2;
    src_idx  = 0;
    src_on   = 1;
    cyc      = 0;
    start    = 1'b1;
    drive_src();
  endtask

  task automatic run_to_done(input int budget, input int pulse_at, output int dcyc);
    dcyc = -1;
    for (int k = 0; k < budget; k++) begin
      if (done === 1'b1) begin dcyc = cyc; return; end
      if (cyc == pulse_at) start = 1'b1;
      tick();
    end
  endtask

  function automatic logic [11:0] bits_from(input int e0);
    logic [11:0] v;
    for (int i = 0; i < 12; i++) v[i] = en_log[e0 + i];
    return v;
  endfunction

  initial begin
    int e0, h0, r0, d0, q0, dcyc, gap, hold_bad;
    logic [CL-1:0] snap;
    logic [7:0] exp0, exp1;

    rows[0]  = '{1'b1, 1'b0, 8'h00, 9'b000000000, 8'h00};
    rows[1]  = '{1'b0, 1'b1, 8'hA5, 9'b100010000, 8'h00};
    rows[2]  = '{1'b0, 1'b1, 8'h3C, 9'b011010000, 8'h00};
    rows[3]  = '{1'b0, 1'b1, 8'h3C, 9'b010010000, 8'h00};
    rows[4]  = '{1'b0, 1'b1, 8'h3C, 9'b011010000, 8'h00};
    rows[5]  = '{1'b0, 1'b1, 8'h3C, 9'b010010000, 8'h00};
    rows[6]  = '{1'b0, 1'b1, 8'h3C, 9'b010010000, 8'h00};
    rows[7]  = '{1'b0, 1'b1, 8'h3C, 9'b011010000, 8'h00};
    rows[8]  = '{1'b0, 1'b1, 8'h3C, 9'b010010000, 8'h00};
    rows[9]  = '{1'b0, 1'b1, 8'h3C, 9'b111010000, 8'h00};
    rows[10] = '{1'b0, 1'b0, 8'h00, 9'b010010010, 8'hFF};
    rows[11] = '{1'b0, 1'b0, 8'h00, 9'b010010000, 8'h00};
    rows[12] = '{1'b0, 1'b0, 8'h00, 9'b011010000, 8'h00};
    rows[13] = '{1'b0, 1'b0, 8'h00, 9'b011010000, 8'h00};
    rows[14] = '{1'b0, 1'b0, 8'h00, 9'b001110010, 8'h0F};
    rows[15] = '{1'b0, 1'b0, 8'h00, 9'b001001100, 8'h00};

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    cfg.cfg_valid = 1'b0; cfg.cfg_data = 8'h00;
    chain = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs",
          {cfg.cfg_ready, config_en, config_data_out, cfg.rb_valid, done, err, busy, le_en, le_nrst},
          9'b0);
    check("reset_rb_data", cfg.rb_data, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Basic load of 0xA5, 0x3C with the chain preloaded to all ones.
    chain = 12'hFFF;
    e0 = en_cnt; h0 = hs_cnt;
    for (int i = 0; i < 16; i++) begin
      start = rows[i].st;
      cfg.cfg_valid = rows[i].vld;
      cfg.cfg_data = rows[i].dat;
      #1;
      check($sformatf("table_row%0d", i),
            {cfg.cfg_ready, config_en, config_data_out, done, busy, le_en, le_nrst, cfg.rb_valid, err},
            rows[i].exp);
      if (rows[i].exp[1]) check($sformatf("table_rb%0d", i), cfg.rb_data, rows[i].exp_rb);
      tick();
    end
    check("basic_shifts", en_cnt - e0, 12);
    check("basic_bits", bits_from(e0), 12'hCA5);
    check("basic_handshakes", hs_cnt - h0, 2);
    check("basic_chain_contents", chain, 12'hA53);

    // Stall: valid drops for 3 cycles right when the second word is due.
    e0 = en_cnt; h0 = hs_cnt; gap = 0; hold_bad = 0; dcyc = -1;
    stall_from = 9; stall_len = 3;
    begin_load(8'hA5, 8'h3C);
    for (int k = 0; k < 40; k++) begin
      if (done === 1'b1) begin dcyc = cyc; break; end
      if (busy && !config_en && (en_cnt - e0) > 0 && (en_cnt - e0) < 12) begin
        gap++;
        if (config_data_out !== en_log[en_cnt - 1]) hold_bad++;
      end
      tick();
    end
    stall_len = 0;
    check("stall_gap_cycles", gap, 3);
    check("stall_dout_held", hold_bad, 0);
    check("stall_shifts", en_cnt - e0, 12);
    check("stall_bits", bits_from(e0), 12'hCA5);
    check("stall_handshakes", hs_cnt - h0, 2);
    check("stall_done_cycle", dcyc, 17);

    // Abort during the fifth shift.
    tick(); tick();
    e0 = en_cnt; d0 = done_cnt; q0 = err_cnt; r0 = rb_cnt;
    begin_load(8'hA5, 8'h3C);
    for (int k = 0; k < 30; k++) begin
      if (config_en && (en_cnt - e0 + 1) == 5) begin abort = 1'b1; tick(); break; end
      tick();
    end
    src_on = 0; cfg.cfg_valid = 1'b0;
    check("abort_next_cycle", {config_en, err, busy}, 3'b010);
    repeat (3) tick();
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_le_nrst_held", {le_en, le_nrst}, 2'b00);
    check("abort_shift_count", en_cnt - e0, 5);
    check("abort_err_pulses", err_cnt - q0, 1);
    check("abort_no_readback", rb_cnt - r0, 0);

    // start+abort together in IDLE, then a start pulse mid-load: both ignored.
    q0 = err_cnt;
    start = 1'b1; abort = 1'b1;
    tick();
    check("start_abort_idle", {busy, err}, 2'b00);
    tick();
    e0 = en_cnt;
    begin_load(8'hA5, 8'h3C);
    run_to_done(40, 4, dcyc);
    check("restart_ignored_done_cycle", dcyc, 14);
    check("restart_ignored_shifts", en_cnt - e0, 12);
    check("restart_ignored_bits", bits_from(e0), 12'hCA5);
    check("no_spurious_err", err_cnt - q0, 0);
    tick();
    check("fabric_released", {le_en, le_nrst}, 2'b11);

    // Synchronous reset at bit 7 of a load, then a clean full load.
    tick();
    e0 = en_cnt;
    begin_load(8'hA5, 8'h3C);
    for (int k = 0; k < 30; k++) begin
      if ((en_cnt - e0) == 7) break;
      tick();
    end
    rst = 1'b1;
    tick();
    check("midload_reset_outputs",
          {cfg.cfg_ready, config_en, config_data_out, cfg.rb_valid, done, err, busy, le_en, le_nrst},
          9'b0);
    rst = 1'b0; src_on = 0; cfg.cfg_valid = 1'b0;
    tick();
    snap = chain;
    for (int k = 0; k < 8; k++) exp0[k] = snap[CL-1-k];
    exp1 = 8'h00;
    for (int k = 0; k < 4; k++) exp1[k] = snap[3-k];
    e0 = en_cnt; r0 = rb_cnt;
    begin_load(8'h5A, 8'hC3);
    run_to_done(40, -1, dcyc);
    check("post_reset_done_cycle", dcyc, 14);
    check("post_reset_shifts", en_cnt - e0, 12);
    check("post_reset_bits", bits_from(e0), 12'h35A);
    tick();
    check("post_reset_rb_count", rb_cnt - r0, 2);
    check("post_reset_rb_word0", rb_log[r0], exp0);
    check("post_reset_rb_word1", rb_log[r0 + 1], exp1);
    check("post_reset_fabric", {le_en, le_nrst}, 2'b11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cram_loader.md
Name: cram_loader

Overview:
- Configuration controller that sequences the serial CRAM chain of a column of fpgacell tiles.
- Accepts configuration words over a valid/ready stream and serializes them LSB-first onto the chain: config_data_out with config_en qualifying each shift.
- Packs the bits returning from the chain tail (the old contents) into readback words.
- Holds the configurable fabric disabled and in reset (le_en/le_nrst) while loading, and releases it only after a complete load.

Parameters:
- CHAIN_LEN, 256, total CRAM bits in the chain; exactly this many shifts per load.
- WORD_W, 8, width of input configuration words and readback words.
- CNT_W, $clog2(CHAIN_LEN+1), localparam, width of the bit counter.

Ports:
- clk  in  1  system/CRAM clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin a load; honoured only in IDLE.
- abort  in  1  cancel an in-progress load.
- cfg_data  in  WORD_W  configuration word; bit 0 is shifted first.
- cfg_valid  in  1  cfg_data valid.
- cfg_ready  out  1  loader accepts cfg_data this cycle.
- config_data_out  out  1  serial bit to the chain head.
- config_en  out  1  chain shift enable.
- config_data_in  in  1  serial bit returning from the chain tail.
- rb_data  out  WORD_W  readback word; first returned bit in bit 0.
- rb_valid  out  1  one-cycle pulse, rb_data valid. No backpressure.
- le_en  out  1  fabric logic enable.
- le_nrst  out  1  fabric logic reset, active-low.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse: load completed.
- err  out  1  one-cycle pulse: load aborted.

Behaviour:
- Reset values (all outputs, one cycle after rst):
  - state IDLE.
  - config_en, config_data_out, cfg_ready, rb_valid, done, err, busy = 0.
  - le_en = 0, le_nrst = 0: the fabric is unconfigured after reset.
  - Shift register, bits_left and bit_cnt = 0.
- States: IDLE, LOAD, FINISH.
- IDLE:
  - start=1 and abort=0 → LOAD next cycle.
  - On entering LOAD: le_en=0, le_nrst=0, bit_cnt=0, readback packer cleared.
  - start and abort together: abort wins; stay IDLE, no err.
- LOAD, word intake:
  - Word register sreg[WORD_W-1:0] with bits_left counter.
  - cfg_ready = (bits_left==0) or (bits_left==1 and shifting this cycle), and bit_cnt+shifts_this_cycle < CHAIN_LEN. This gives back-to-back words with no bubble.
  - On cfg_valid&&cfg_ready: sreg=cfg_data, bits_left=WORD_W.
- LOAD, shifting:
  - config_en = (state==LOAD && bits_left!=0).
  - config_data_out = sreg[0] whenever config_en=1; otherwise it holds its last value.
  - Each shift: sreg>>=1, bits_left--, bit_cnt++, config_data_in captured into the readback packer.
  - Starvation (cfg_valid low, no bits left): config_en=0 and the chain holds. No data is lost.
- LOAD, completion:
  - The shift with bit_cnt==CHAIN_LEN-1 is the last one; next state is FINISH.
  - Unshifted bits remaining in sreg are discarded.
  - cfg_ready is 0 from the last shift onward.
- Readback:
  - Every WORD_W captured bits: rb_valid pulses the following cycle with the packed word.
  - If CHAIN_LEN%WORD_W≠0, the final partial word is emitted in FINISH, zero-padded in the high bits.
- FINISH (one cycle):
  - done=1, le_nrst←1, le_en←1, → IDLE.
  - The fabric stays enabled until the next start.
- Abort in LOAD:
  - Next cycle: IDLE, config_en=0, err=1 for one cycle.
  - le_en and le_nrst remain 0. No partial readback word is emitted. sreg is discarded.
- start while busy is ignored. abort in IDLE or FINISH is ignored.
- rst mid-load forces all reset values; the chain contents are undefined and the fabric stays held.
- Latency with continuous supply:
  - start@t0 → cfg_ready@t1 → first config_en@t2.
  - config_en is high for exactly CHAIN_LEN consecutive cycles.
  - done appears on the cycle after the last shift.

Decomposition:
- Package cram_loader_pkg: state enum typedef (IDLE/LOAD/FINISH), and a function computing CNT_W.
- Natural sub-module: cram_rb_packer.
  - Serial-to-parallel readback packer with clear, bit_in, bit_en and flush inputs, and rb_data/rb_valid outputs.
  - It is reusable for later readback/verify blocks.

Test Plan:
- Basic load, CHAIN_LEN=12, WORD_W=8, words 0xA5 then 0x3C, continuous valid:
  - config_data_out sequence 1,0,1,0,0,1,0,1,0,0,1,1 on 12 consecutive config_en cycles.
  - High 4 bits of 0x3C are discarded; exactly 2 handshakes.
  - done at t14; le_en=le_nrst=1 at t15.
- Readback, chain model preloaded 0xFFF, same load:
  - rb_valid twice: rb_data 0xFF, then 0x0F in FINISH.
  - The chain model then holds the new 12 bits.
- Stall: drop cfg_valid for 3 cycles after the first word is consumed:
  - config_en low exactly 3 cycles; config_data_out held.
  - Total config_en count is still 12; bit order unchanged.
- Abort after 5 shifts:
  - Next cycle config_en=0, err=1, busy=0.
  - done never pulses; le_nrst stays 0; only 5 shifts occurred.
- start pulsed during LOAD, and start+abort together in IDLE: both ignored, with no extra shifts and no err. A subsequent clean start loads normally.
- rst asserted at bit 7 of a load: all outputs at reset values on the next cycle. A new start afterwards performs a full 12-bit load with bit_cnt starting at 0.
